// File: rtl/image_unloader.sv
// image_unloader: streams the image BRAM out to the output FIFO in raster order
// through a 2-entry skid buffer that absorbs read latency and FIFO backpressure.
module image_unloader #(
  parameter int WIDTH = 720,
  parameter int HEIGHT = 540,
  parameter int IMAGE_SIZE = WIDTH * HEIGHT,
  localparam int AW = IMAGE_SIZE > 1 ? $clog2(IMAGE_SIZE) : 1,
  localparam int CW = $clog2(IMAGE_SIZE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] bram_rd_addr,
  input  logic [23:0]   bram_rd_data,
  output logic          out_wr_en,
  input  logic          out_full,
  output logic [23:0]   out_din,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE);
  state_t state, state_nx;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic [23:0] b0, b1, b0_p;
  logic [1:0] cnt, cnt_p;
  logic [2:0] occ;
  logic in_flight, pop, issue;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (start ? READ : IDLE) :
               state == READ  ? (rd_cnt == LAST ? DRAIN : READ) :
               state == DRAIN ? (pop && wr_cnt == LAST - CW'(1) ? DONE : DRAIN) : IDLE;
  always_comb begin
    busy = state == READ || state == DRAIN;
    done = state == DONE;
    out_wr_en = cnt != 2'd0 && !out_full;
    out_din = cnt != 2'd0 ? b0 : '0;
  end
  assign pop = out_wr_en;
  // The accepting start edge already issues address 0, so data lands one edge later.
  always_comb begin
    occ = 3'(cnt) + 3'(in_flight) - 3'(pop);
    issue = state == IDLE ? start : (state == READ && rd_cnt != LAST && occ <= 3'd1);
    cnt_p = cnt - 2'(pop);
    b0_p = pop ? b1 : b0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      bram_rd_addr <= '0;
      in_flight <= 1'b0;
      cnt <= '0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      in_flight <= issue;
      cnt <= cnt_p + 2'(in_flight);
      b0 <= in_flight && cnt_p == 2'd0 ? bram_rd_data : b0_p;
      if (in_flight && cnt_p == 2'd1) b1 <= bram_rd_data;
      if (issue) begin
        rd_cnt <= rd_cnt + CW'(1);
        bram_rd_addr <= rd_cnt[AW-1:0];
      end
      if (pop) wr_cnt <= wr_cnt + CW'(1);
      if (state == DONE) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_image_unloader.sv
// tb_image_unloader: directed/random frame readouts scored against a pixel-order and timing model.
module tb_image_unloader;
  localparam int N = 12;
  logic clock = 1'b0, reset = 1'b1, a_start = 1'b0, b_start = 1'b0;
  logic [3:0] a_addr;
  logic [0:0] b_addr;
  logic [23:0] a_data, b_data, a_din, b_din, b_pix;
  logic a_wr, a_full, a_busy, a_done, b_wr, b_busy, b_done;
  logic b_full = 1'b0, rnd_full = 1'b0, force_full = 1'b0, rbit = 1'b0;
  int checks = 0, errors = 0, cyc = 0, e0 = 0, viol = 0, busy_lo = 0, amax_all = 0, bmax = 0;
  logic [23:0] wq[$], bq[$];
  int wc[$], dc[$], bc[$], bd[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin #1; rbit = 1'($urandom_range(0, 1)); end

  assign a_full = rnd_full ? rbit : force_full;
  assign a_data = 24'h010101 * 24'(a_addr);
  assign b_data = b_pix;

  image_unloader #(.WIDTH(4), .HEIGHT(3)) ua (
    .clock(clock), .reset(reset), .start(a_start), .bram_rd_addr(a_addr), .bram_rd_data(a_data),
    .out_wr_en(a_wr), .out_full(a_full), .out_din(a_din), .busy(a_busy), .done(a_done));
  image_unloader #(.WIDTH(1), .HEIGHT(1)) ub (
    .clock(clock), .reset(reset), .start(b_start), .bram_rd_addr(b_addr), .bram_rd_data(b_data),
    .out_wr_en(b_wr), .out_full(b_full), .out_din(b_din), .busy(b_busy), .done(b_done));

  always @(negedge clock) begin
    if (a_wr) begin wq.push_back(a_din); wc.push_back(cyc); end
    if (a_wr && a_full) viol++;
    if (a_wr && !a_busy) busy_lo++;
    if (a_done) dc.push_back(cyc);
    if (int'(a_addr) > amax_all) amax_all = int'(a_addr);
    if (b_wr) begin bq.push_back(b_din); bc.push_back(cyc); end
    if (b_done) bd.push_back(cyc);
    if (int'(b_addr) > bmax) bmax = int'(b_addr);
  end

  function automatic logic [23:0] px(input int i);
    return 24'(i) * 24'h010101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_a();
    @(posedge clock); #1 a_start = 1'b1;
    @(posedge clock); #1 a_start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_a(input string tag, input int limit);
    int t = 0;
    do begin @(negedge clock); t++; end while (!a_done && t < limit);
    chk({tag, "_done_seen"}, 32'(a_done), 1);
    chk({tag, "_busy_in_done"}, 32'(a_busy), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_frame(input string tag, input int base);
    chk({tag, "_count"}, wq.size() - base, N);
    for (int i = 0; i < N && base + i < wq.size(); i++) chk({tag, "_px"}, 32'(wq[base + i]), 32'(px(i)));
  endtask

  initial begin
    int base, dbase, v0, wr, mx, t, n;
    b_pix = 24'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_wr", 32'(a_wr), 0);
    chk("rst_din", 32'(a_din), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_b_wr", 32'(b_wr), 0);
    @(posedge clock); #1 reset = 1'b0;
    // clean frame: exact timing
    base = wq.size(); dbase = dc.size();
    start_a();
    wait_a("t1", 100);
    check_frame("t1", base);
    chk("t1_first_wr", wc[base] - e0, 1);
    chk("t1_consecutive", wc[base + N - 1] - wc[base], N - 1);
    chk("t1_done_after_last", dc[dbase] - wc[base + N - 1], 1);
    chk("t1_done_pulses", dc.size() - dbase, 1);
    chk("t1_busy_at_writes", busy_lo, 0);
    // random 50% backpressure
    base = wq.size(); v0 = viol;
    rnd_full = 1'b1;
    start_a();
    wait_a("t2", 400);
    rnd_full = 1'b0;
    check_frame("t2", base);
    chk("t2_wr_while_full", viol - v0, 0);
    // full held for 20 cycles from the cycle after start
    base = wq.size(); wr = 0; mx = 0;
    start_a();
    force_full = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (a_wr) wr++;
      if (int'(a_addr) > mx) mx = int'(a_addr);
    end
    @(posedge clock); #1 force_full = 1'b0;
    chk("t3_no_writes", wr, 0);
    chk("t3_reads_le2", 32'(mx <= 1), 1);
    wait_a("t3", 100);
    check_frame("t3", base);
    // start during READ and coincident with done are ignored
    base = wq.size(); dbase = dc.size();
    start_a();
    t = e0;
    repeat (3) @(posedge clock);
    #1 a_start = 1'b1;
    @(posedge clock); #1 a_start = 1'b0;
    while (cyc < t + N + 1) begin @(posedge clock); #1; end
    a_start = 1'b1;
    chk("t4_done_now", 32'(a_done), 1);
    @(posedge clock); #1 a_start = 1'b0;
    repeat (30) @(negedge clock);
    chk("t4_writes", wq.size() - base, N);
    chk("t4_done_pulses", dc.size() - dbase, 1);
    chk("t4_idle", 32'(a_busy), 0);
    check_frame("t4", base);
    base = wq.size();
    start_a();
    wait_a("t4b", 100);
    check_frame("t4b", base);
    // reset after the 5th write
    base = wq.size(); t = 0;
    start_a();
    while (wq.size() - base < 5 && t < 100) begin @(posedge clock); t++; end
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("t5_wr", 32'(a_wr), 0);
    chk("t5_din", 32'(a_din), 0);
    chk("t5_addr", 32'(a_addr), 0);
    chk("t5_busy", 32'(a_busy), 0);
    chk("t5_done", 32'(a_done), 0);
    n = wq.size();
    repeat (10) @(negedge clock);
    chk("t5_no_more_wr", wq.size(), n);
    for (int i = 0; i < n - base; i++) chk("t5_prefix_px", 32'(wq[base + i]), 32'(px(i)));
    @(posedge clock); #1 reset = 1'b0;
    base = wq.size();
    start_a();
    wait_a("t5b", 100);
    check_frame("t5b", base);
    chk("t5b_first_wr", wc[base] - e0, 1);
    chk("addr_max", amax_all, N - 1);
    // single-pixel image
    base = bq.size(); dbase = bd.size();
    @(posedge clock); #1 b_start = 1'b1;
    @(posedge clock); #1 b_start = 1'b0;
    e0 = cyc; t = 0;
    do begin @(negedge clock); t++; end while (!b_done && t < 50);
    repeat (3) @(negedge clock);
    chk("t6_writes", bq.size() - base, 1);
    chk("t6_px", 32'(bq[base]), 32'(b_pix));
    chk("t6_first_wr", bc[base] - e0, 1);
    chk("t6_done_after", bd[dbase] - bc[base], 1);
    chk("t6_addr_max", bmax, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_unloader.md
Name: image_unloader

Overview:
Reads the finished, lane-highlighted RGB frame out of the image BRAM read port and streams it into an output FIFO, one 24-bit pixel per write, in raster order (address 0 to IMAGE_SIZE-1).
Started by the highlight stage's finish pulse; it is the reader end of the image BRAM, which the loader and highlight stages write.
Absorbs the BRAM's 1-cycle read latency and FIFO backpressure without dropping or duplicating pixels.

Parameters:
WIDTH, 720, image width in pixels
HEIGHT, 540, image height in pixels
IMAGE_SIZE, WIDTH*HEIGHT, pixel count; sets the address width $clog2(IMAGE_SIZE)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse (finish_draw_a_line); begins one frame readout
bram_rd_addr  out  $clog2(IMAGE_SIZE)  image BRAM read address
bram_rd_data  in  24  image BRAM read data; valid 1 cycle after its address
out_wr_en  out  1  write strobe to output FIFO
out_full  in  1  output FIFO full
out_din  out  24  pixel to output FIFO, {R,G,B} as stored
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last pixel is written

Behaviour:
- Reset values: bram_rd_addr=0, out_wr_en=0, out_din=0, busy=0, done=0. State is IDLE, counters are 0, skid buffer is empty, in-flight flag is clear.
- One clock domain; all state updates on the rising edge of clock. Reset has priority over every other input.
- States:
  - IDLE: accept start, go to READ. start is ignored in every other state.
  - READ: issue reads and push pixels. Go to DRAIN once read counter = IMAGE_SIZE.
  - DRAIN: push the remaining buffered and in-flight pixels. Go to DONE when the write counter reaches IMAGE_SIZE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Read issue:
  - A read is issued in a READ cycle iff rd_cnt < IMAGE_SIZE and (buffered + in-flight − pops this cycle) ≤ 1.
  - bram_rd_addr = rd_cnt, driven from a register. rd_cnt increments on each issue.
  - An in-flight read lands in the 2-entry skid buffer on the following edge.
- Write side:
  - out_wr_en = buffer non-empty AND !out_full, combinational from registered buffer state.
  - out_din = buffer head whenever the buffer is non-empty, else 0.
  - A pop occurs on every edge where out_wr_en=1; wr_cnt increments on each pop.
- Buffer capacity 2: buffered + in-flight never exceeds 2. No overflow is possible with out_full held high indefinitely.
- Simultaneous landing and pop in the same cycle: occupancy is unchanged and order is preserved (FIFO order).
- Latency: with start sampled at edge E0 and out_full low:
  - address 0 is presented after E0;
  - out_wr_en is first high in the cycle after E1;
  - first pixel is written at E2;
  - sustained rate is 1 pixel/cycle;
  - the last pixel is written at E(IMAGE_SIZE+1);
  - done is high in the following cycle.
- Backpressure: while out_full=1, out_wr_en=0 and reads stall once buffer + in-flight = 2. Streaming resumes the cycle out_full drops.
- Counters are sized to hold IMAGE_SIZE and do not wrap. Readout ends exactly at address IMAGE_SIZE-1; no address beyond it is issued.
- busy=1 in READ and DRAIN, 0 in IDLE and DONE.
- A start coincident with done (DONE state) is ignored. A new frame requires a start while in IDLE.
- Reset mid-operation: on the next edge the block returns to reset values. No further out_wr_en occurs, the partial frame is abandoned and the buffer is flushed.
- Pixel data is passed through unmodified; no arithmetic on the data path.

Test Plan:
- WIDTH=4, HEIGHT=3, BRAM[a]=24'h010101*a, out_full=0, start pulse:
  - exactly 12 writes on consecutive cycles, values 000000..0B0B0B in order;
  - first write 2 cycles after start;
  - done pulse 1 cycle after the 12th write; busy high throughout.
- Same setup with out_full driven by a random 50% pattern:
  - 12 writes, correct order, no duplicates;
  - out_wr_en never high while out_full=1.
- out_full=1 for 20 cycles starting at the cycle after start:
  - zero writes and at most 2 reads issued during those cycles;
  - after release, all 12 pixels arrive in order.
- Start pulse during READ and start coincident with done:
  - each is ignored; exactly one frame (12 writes) per accepted start;
  - a second start in IDLE yields a second identical 12-pixel frame.
- reset asserted after the 5th write:
  - the next cycle has all outputs at 0, no further writes, and state IDLE;
  - a subsequent start restarts from address 0 with pixel 000000.
- WIDTH=1, HEIGHT=1:
  - single write of BRAM[0], done pulse one cycle later;
  - bram_rd_addr never exceeds 0.
